// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA sync timing generator with pixel strobe, frame pulse and cursor blink
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous active-high reset
//   hsync      horizontal sync, active-low, registered
//   vsync      vertical sync, active-low, registered
//   video_on   high while (pixel_x, pixel_y) is inside the visible area, registered
//   p_tick     one-clk pixel enable, one clk in every four
//   pixel_x    current horizontal count
//   pixel_y    current vertical count
//   frame_end  one-clk pulse on the last pixel of the frame
//   parpadeo   cursor blink level, toggles every BLINK_FRAMES frames

module vga_sync_gen #(
    parameter int H_DISPLAY    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_DISPLAY    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_end,
    output logic       parpadeo
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int XW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int YW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [XW-1:0] X_MAX      = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_MAX      = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_VIS      = XW'(H_DISPLAY);
    localparam logic [YW-1:0] Y_VIS      = YW'(V_DISPLAY);
    localparam logic [XW-1:0] HS_START   = XW'(H_DISPLAY + H_FRONT);
    localparam logic [XW-1:0] HS_END     = XW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [YW-1:0] VS_START   = YW'(V_DISPLAY + V_FRONT);
    localparam logic [YW-1:0] VS_END     = YW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [FW-1:0] FRAME_MAX  = FW'(BLINK_FRAMES - 1);

    logic [1:0]    div_cnt;
    logic [XW-1:0] x_cnt;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_cnt;
    logic [YW-1:0] y_next;
    logic [FW-1:0] frame_cnt;
    logic          x_last;
    logic          y_last;
    logic          hsync_q;
    logic          vsync_q;
    logic          video_q;
    logic          blink_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= 2'd0;
        end else begin
            div_cnt <= div_cnt + 2'd1;
        end
    end

    // div_cnt is already cleared during reset; the reset term keeps the
    // strobe low even while the reset edge is propagating.
    assign p_tick = ~reset & (div_cnt == 2'd3);

    assign x_last = (x_cnt == X_MAX);
    assign y_last = (y_cnt == Y_MAX);

    always_comb begin
        x_next = x_cnt;
        y_next = y_cnt;
        if (p_tick) begin
            if (x_last) begin
                x_next = '0;
                y_next = y_last ? '0 : y_cnt + YW'(1);
            end else begin
                x_next = x_cnt + XW'(1);
            end
        end
    end

    // Sync and blanking are decoded from the next position so the registered
    // outputs line up with the counters they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            video_q <= 1'b1;
        end else begin
            x_cnt   <= x_next;
            y_cnt   <= y_next;
            hsync_q <= ~((x_next >= HS_START) && (x_next <= HS_END));
            vsync_q <= ~((y_next >= VS_START) && (y_next <= VS_END));
            video_q <= (x_next < X_VIS) && (y_next < Y_VIS);
        end
    end

    assign frame_end = p_tick & x_last & y_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FRAME_MAX) begin
                frame_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign video_on = video_q;
    assign pixel_x  = 10'(x_cnt);
    assign pixel_y  = 10'(y_cnt);
    assign parpadeo = blink_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - randomized reference-model bench for vga_sync_gen

module tb_vga_sync_gen;

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit vo;
        bit pt;
        bit fe;
        bit pp;
    } exp_t;

    logic clk;
    logic rst_d;
    logic rst_s;

    logic       hs_d, vs_d, vo_d, pt_d, fe_d, pp_d;
    logic [9:0] px_d, py_d;
    logic       hs_s, vs_s, vo_s, pt_s, fe_s, pp_s;
    logic [9:0] px_s, py_s;

    int  vectors;
    int  miscompares;
    bit  done;

    longint k_d;
    longint k_s;

    // Full-size 640x480 timing.
    vga_sync_gen dut_d (
        .clk       (clk),
        .reset     (rst_d),
        .hsync     (hs_d),
        .vsync     (vs_d),
        .video_on  (vo_d),
        .p_tick    (pt_d),
        .pixel_x   (px_d),
        .pixel_y   (py_d),
        .frame_end (fe_d),
        .parpadeo  (pp_d)
    );

    // Shrunken raster so many frames and blink periods fit in a short run.
    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .BLINK_FRAMES(2)
    ) dut_s (
        .clk       (clk),
        .reset     (rst_s),
        .hsync     (hs_s),
        .vsync     (vs_s),
        .video_on  (vo_s),
        .p_tick    (pt_s),
        .pixel_x   (px_s),
        .pixel_y   (py_s),
        .frame_end (fe_s),
        .parpadeo  (pp_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges seen since the last reset release.
    always @(posedge clk or posedge rst_d) begin
        if (rst_d) k_d <= 0;
        else       k_d <= k_d + 1;
    end

    always @(posedge clk or posedge rst_s) begin
        if (rst_s) k_s <= 0;
        else       k_s <= k_s + 1;
    end

    // Expected outputs after k clock edges: one pixel per 4 edges, raster
    // position and frame number follow by division.
    function automatic exp_t model(input longint k, input int hd, input int hf, input int hsw,
                                   input int hb, input int vd, input int vf, input int vsw,
                                   input int vb, input int bf);
        exp_t   e;
        longint p;
        longint f;
        int     ht;
        int     vt;
        ht   = hd + hf + hsw + hb;
        vt   = vd + vf + vsw + vb;
        p    = k / 4;
        e.x  = int'(p % ht);
        e.y  = int'((p / ht) % vt);
        f    = p / (ht * vt);
        e.pt = ((k % 4) == 3);
        e.hs = !((e.x >= hd + hf) && (e.x < hd + hf + hsw));
        e.vs = !((e.y >= vd + vf) && (e.y < vd + vf + vsw));
        e.vo = (e.x < hd) && (e.y < vd);
        e.fe = e.pt && (e.x == ht - 1) && (e.y == vt - 1);
        e.pp = ((f / bf) % 2) == 1;
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_d();
        exp_t e;
        e = model(k_d, 640, 16, 96, 48, 480, 10, 2, 33, 30);
        check_val("d_x",  32'(px_d), 32'(e.x));
        check_val("d_y",  32'(py_d), 32'(e.y));
        check_val("d_hs", 32'(hs_d), 32'(e.hs));
        check_val("d_vs", 32'(vs_d), 32'(e.vs));
        check_val("d_vo", 32'(vo_d), 32'(e.vo));
        check_val("d_pt", 32'(pt_d), 32'(e.pt));
        check_val("d_fe", 32'(fe_d), 32'(e.fe));
        check_val("d_pp", 32'(pp_d), 32'(e.pp));
    endtask

    task automatic cmp_s();
        exp_t e;
        e = model(k_s, 8, 2, 3, 2, 5, 1, 2, 1, 2);
        check_val("s_x",  32'(px_s), 32'(e.x));
        check_val("s_y",  32'(py_s), 32'(e.y));
        check_val("s_hs", 32'(hs_s), 32'(e.hs));
        check_val("s_vs", 32'(vs_s), 32'(e.vs));
        check_val("s_vo", 32'(vo_s), 32'(e.vo));
        check_val("s_pt", 32'(pt_s), 32'(e.pt));
        check_val("s_fe", 32'(fe_s), 32'(e.fe));
        check_val("s_pp", 32'(pp_s), 32'(e.pp));
    endtask

    // Interval trackers, counted in clk cycles at the falling edge.
    longint cyc_d, cyc_s;
    longint hs_fall, pt_last, vo_fall, fe_last;
    bit     hs_prev, vo_prev, pp_prev;
    int     pp_toggles;
    int     fe_seen;

    always @(negedge clk) begin
        if (!done) begin
            cmp_d();
            cmp_s();
            if (rst_d) begin
                cyc_d   = 0;
                hs_fall = -1;
                pt_last = -1;
                vo_fall = -1;
                hs_prev = 1'b1;
                vo_prev = 1'b1;
            end else begin
                cyc_d++;
                if (hs_prev && !hs_d) begin
                    check_val("hs_fall_x", 32'(px_d), 32'd656);
                    if (hs_fall >= 0) check_val("line_period", 32'(cyc_d - hs_fall), 32'd3200);
                    hs_fall = cyc_d;
                end
                if (!hs_prev && hs_d && hs_fall >= 0)
                    check_val("hs_low", 32'(cyc_d - hs_fall), 32'd384);
                if (vo_prev && !vo_d && py_d < 10'd480) begin
                    check_val("vo_fall_x", 32'(px_d), 32'd640);
                    vo_fall = cyc_d;
                end
                if (pt_d) begin
                    if (pt_last >= 0) check_val("pt_period", 32'(cyc_d - pt_last), 32'd4);
                    pt_last = cyc_d;
                end
                hs_prev = hs_d;
                vo_prev = vo_d;
            end
            if (rst_s) begin
                cyc_s   = 0;
                fe_last = -1;
                pp_prev = 1'b0;
            end else begin
                cyc_s++;
                if (fe_s) begin
                    fe_seen++;
                    if (fe_last >= 0) check_val("fe_period", 32'(cyc_s - fe_last), 32'd540);
                    fe_last = cyc_s;
                end
                if (pp_s != pp_prev) pp_toggles++;
                pp_prev = pp_s;
            end
        end
    end

    task automatic wait_negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vectors    = 0;
        miscompares = 0;
        done       = 1'b0;
        pp_toggles = 0;
        fe_seen    = 0;
        k_d        = 0;
        k_s        = 0;
        rst_d      = 1'b1;
        rst_s      = 1'b1;

        wait_negs(3);
        #2;
        rst_d = 1'b0;
        rst_s = 1'b0;

        // Three full lines of the default raster.
        wait_negs(3 * 3200 + 100);

        // Reset between edges at x=700 on the default raster.
        begin
            bit found = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                @(negedge clk);
                if (px_d == 10'd700) begin
                    found = 1'b1;
                    break;
                end
            end
            check_val("wait_x700", 32'(found), 32'd1);
            #2;
            rst_d = 1'b1;
            #1;
            cmp_d();
            wait_negs(2);
            #2;
            rst_d = 1'b0;
        end

        // Reset between edges at x=10, y=4 on the small raster.
        begin
            bit found = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (px_s == 10'd10 && py_s == 10'd4) begin
                    found = 1'b1;
                    break;
                end
            end
            check_val("wait_s_xy", 32'(found), 32'd1);
            #2;
            rst_s = 1'b1;
            #1;
            cmp_s();
            wait_negs(2);
            #2;
            rst_s = 1'b0;
        end

        // Randomly placed asynchronous resets on either instance.
        for (int r = 0; r < 4; r++) begin
            int  which;
            wait_negs(int'($urandom_range(300, 2500)));
            #($urandom_range(1, 3));
            which = int'($urandom_range(0, 1));
            if (which == 0) begin
                rst_d = 1'b1;
                #1;
                cmp_d();
            end else begin
                rst_s = 1'b1;
                #1;
                cmp_s();
            end
            wait_negs(int'($urandom_range(1, 3)));
            #2;
            rst_d = 1'b0;
            rst_s = 1'b0;
        end

        // Long uninterrupted run so the small raster blinks several times.
        wait_negs(7000);

        check_val("pp_toggled", 32'(pp_toggles >= 4), 32'd1);
        check_val("fe_seen",    32'(fe_seen >= 10), 32'd1);

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
